// File: rtl/mips_instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_encoder_if
// Purpose  : Symbolic-instruction input channel and instruction-memory write
//            port of the MIPS instruction encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_instr_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            op_sel;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            shamt;
  logic [15:0]           imm;
  logic [25:0]           target;
  logic                  imem_wen;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_valid, op_sel, rs, rt, rd, shamt, imm, target,
    input  in_ready, imem_wen, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, op_sel, rs, rt, rd, shamt, imm, target,
    output in_ready, imem_wen, imem_addr, imem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_encoder
// Purpose  : Packs symbolic instructions into 32-bit MIPS words and writes
//            them to consecutive instruction-memory addresses.
// Revision : 1.0 - initial release
// ============================================================================
module mips_instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  mips_instr_encoder_if.slave   bus,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  load_done,
  output logic                  overflow,
  output logic                  op_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] c_LAST      = '1;
  localparam logic [31:0]           c_EXIT_WORD = 32'hFC00_0000;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH:0]   r_words;
  logic                  r_is_exit;
  logic                  r_done;
  logic                  r_overflow;
  logic                  r_op_err;
  logic                  w_hs;
  logic                  w_arm;
  logic                  w_op_valid;
  logic                  w_is_exit;
  logic [31:0]           w_word;

  function automatic logic [31:0] f_rtype(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                          input logic [4:0] f_rd, input logic [4:0] f_sh,
                                          input logic [5:0] f_funct);
    return {6'h00, f_rs, f_rt, f_rd, f_sh, f_funct};
  endfunction

  assign bus.in_ready   = (r_state == S_ACCEPT);
  assign bus.imem_wen   = (r_state == S_WRITE);
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign words_written  = r_words;
  assign load_done      = r_done;
  assign overflow       = r_overflow;
  assign op_err         = r_op_err;

  assign w_hs  = bus.in_valid && (r_state == S_ACCEPT);
  assign w_arm = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // op_sel -> packed word; fields the core ignores are forced to zero
  always_comb begin
    w_word     = '0;
    w_op_valid = 1'b1;
    w_is_exit  = 1'b0;
    case (bus.op_sel)
      5'd0:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h20);
      5'd1:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h22);
      5'd2:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h24);
      5'd3:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h25);
      5'd4:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h27);
      5'd5:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h2A);
      5'd6:  w_word = f_rtype(5'd0, bus.rt, bus.rd, bus.shamt, 6'h00);
      5'd7:  w_word = f_rtype(5'd0, bus.rt, bus.rd, bus.shamt, 6'h02);
      5'd8:  w_word = f_rtype(bus.rs, bus.rt, 5'd0, 5'd0, 6'h18);
      5'd9:  w_word = f_rtype(bus.rs, bus.rt, 5'd0, 5'd0, 6'h1A);
      5'd10: w_word = f_rtype(5'd0, 5'd0, bus.rd, 5'd0, 6'h12);
      5'd11: w_word = f_rtype(5'd0, 5'd0, bus.rd, 5'd0, 6'h10);
      5'd12: w_word = f_rtype(bus.rs, 5'd0, 5'd0, 5'd0, 6'h08);
      // lw uses 0x22 to match the core decoder, not the standard 0x23
      5'd13: w_word = {6'h22, bus.rs, bus.rt, bus.imm};
      5'd14: w_word = {6'h2B, bus.rs, bus.rt, bus.imm};
      5'd15: w_word = {6'h04, bus.rs, bus.rt, bus.imm};
      5'd16: w_word = {6'h08, bus.rs, bus.rt, bus.imm};
      5'd17: w_word = {6'h0A, bus.rs, bus.rt, bus.imm};
      5'd18: w_word = {6'h0C, bus.rs, bus.rt, bus.imm};
      5'd19: w_word = {6'h0D, bus.rs, bus.rt, bus.imm};
      5'd20: w_word = {6'h02, bus.target};
      5'd21: w_word = {6'h03, bus.target};
      5'd22: begin
        w_word    = c_EXIT_WORD;
        w_is_exit = 1'b1;
      end
      default: w_op_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_ACCEPT;
      S_ACCEPT:       if (w_hs && w_op_valid) w_state_nxt = S_WRITE;
      S_WRITE:        w_state_nxt = (r_is_exit || (r_addr == c_LAST)) ? S_DONE : S_ACCEPT;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_addr <= c_BASE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_words     <= '0;
      r_is_exit   <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_op_err    <= 1'b0;
    end else begin
      r_op_err <= w_hs && !w_op_valid;
      if (w_arm) begin
        r_next_addr <= c_BASE;
        r_words     <= '0;
        r_done      <= 1'b0;
        r_overflow  <= 1'b0;
      end
      if (w_hs && w_op_valid) begin
        r_addr    <= r_next_addr;
        r_wdata   <= w_word;
        r_is_exit <= w_is_exit;
      end
      if (r_state == S_WRITE) begin
        r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
        r_words     <= r_words + (ADDR_WIDTH+1)'(1);
        if (r_is_exit) begin
          r_done <= 1'b1;
        end else if (r_addr == c_LAST) begin
          r_done     <= 1'b1;
          r_overflow <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_instr_encoder
// Purpose  : Directed self-checking bench for mips_instr_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_instr_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start2;
  logic [8:0] words_written;
  logic       load_done;
  logic       overflow;
  logic       op_err;
  logic [2:0] words_written2;
  logic       load_done2;
  logic       overflow2;
  logic       op_err2;
  int         n_checks = 0;
  int         n_fail   = 0;

  mips_instr_encoder_if #(.ADDR_WIDTH(8)) bus8 ();
  mips_instr_encoder_if #(.ADDR_WIDTH(2)) bus2 ();

  mips_instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus8.slave),
    .words_written(words_written), .load_done(load_done),
    .overflow(overflow), .op_err(op_err)
  );

  mips_instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2.slave),
    .words_written(words_written2), .load_done(load_done2),
    .overflow(overflow2), .op_err(op_err2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in ACCEPT; returns at the negedge after the write.
  task automatic send(input string tag, input logic [4:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] c, input logic [4:0] sh,
                      input logic [15:0] im, input logic [25:0] tg,
                      input logic [7:0] exp_addr, input logic [31:0] exp_data);
    bus8.op_sel = op; bus8.rs = a; bus8.rt = b; bus8.rd = c;
    bus8.shamt = sh; bus8.imm = im; bus8.target = tg; bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.op_sel = 5'd31; bus8.rs = '1; bus8.rt = '1; bus8.rd = '1;
    bus8.shamt = '1; bus8.imm = '1; bus8.target = '1;
    check({tag, "_wen"},  32'(bus8.imem_wen), 32'd1);
    check({tag, "_addr"}, 32'(bus8.imem_addr), 32'(exp_addr));
    check({tag, "_data"}, bus8.imem_wdata, exp_data);
    @(negedge clk);
    check({tag, "_wen_off"}, 32'(bus8.imem_wen), 32'd0);
    check({tag, "_hold"},    bus8.imem_wdata, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    bus8.in_valid = 1'b0; bus8.op_sel = '0; bus8.rs = '0; bus8.rt = '0; bus8.rd = '0;
    bus8.shamt = '0; bus8.imm = '0; bus8.target = '0;
    bus2.in_valid = 1'b0; bus2.op_sel = '0; bus2.rs = '0; bus2.rt = '0; bus2.rd = '0;
    bus2.shamt = '0; bus2.imm = '0; bus2.target = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", 32'(bus8.in_ready), 32'd0);
    check("rst_wen",   32'(bus8.imem_wen), 32'd0);
    check("rst_addr",  32'(bus8.imem_addr), 32'd0);
    check("rst_data",  bus8.imem_wdata, 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_flags", {29'd0, load_done, overflow, op_err}, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus8.in_ready), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("arm_ready", 32'(bus8.in_ready), 32'd1);

    send("add", 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 8'd0, 32'h0022_1820);
    check("add_words", 32'(words_written), 32'd1);
    send("lw",  5'd13, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 8'd1, 32'h8BA8_0004);
    send("sll", 5'd6, 5'd7, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0, 8'd2, 32'h0005_2080);
    send("j",   5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 8'd3, 32'h0800_0010);
    check("pre_exit_done", 32'(load_done), 32'd0);
    send("exit", 5'd22, 5'd31, 5'd3, 5'd9, 5'd4, 16'h1234, 26'h3FF_FFFF, 8'd4, 32'hFC00_0000);
    check("exit_done",  32'(load_done), 32'd1);
    check("exit_ready", 32'(bus8.in_ready), 32'd0);
    check("exit_words", 32'(words_written), 32'd5);
    check("exit_ovf",   32'(overflow), 32'd0);

    bus8.op_sel = 5'd0; bus8.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_no_wen", 32'(bus8.imem_wen), 32'd0);
    end
    bus8.in_valid = 1'b0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rearm_done",  32'(load_done), 32'd0);
    check("rearm_words", 32'(words_written), 32'd0);
    check("rearm_ready", 32'(bus8.in_ready), 32'd1);

    bus8.op_sel = 5'd25; bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("operr_pulse", 32'(op_err), 32'd1);
    check("operr_wen",   32'(bus8.imem_wen), 32'd0);
    check("operr_ready", 32'(bus8.in_ready), 32'd1);
    @(negedge clk);
    check("operr_clear", 32'(op_err), 32'd0);
    check("operr_wen2",  32'(bus8.imem_wen), 32'd0);
    send("addi", 5'd16, 5'd0, 5'd1, 5'd0, 5'd0, 16'hFFFF, 26'h0, 8'd0, 32'h2001_FFFF);

    // Reset asserted just after a handshake aborts the pending write.
    bus8.op_sel = 5'd0; bus8.rs = 5'd1; bus8.rt = 5'd2; bus8.rd = 5'd3; bus8.shamt = 5'd0;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus8.in_valid = 1'b0;
    #1;
    check("arst_wen",   32'(bus8.imem_wen), 32'd0);
    check("arst_addr",  32'(bus8.imem_addr), 32'd0);
    check("arst_data",  bus8.imem_wdata, 32'd0);
    check("arst_words", 32'(words_written), 32'd0);
    check("arst_flags", {28'd0, bus8.in_ready, load_done, overflow, op_err}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("arst_no_wen", 32'(bus8.imem_wen), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_done", 32'(load_done), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send("post_rst", 5'd0, 5'd1, 5'd2, 5'd7, 5'd0, 16'h0, 26'h0, 8'd0, 32'h0022_3820);

    // Four-word memory filled without an exit instruction.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus2.op_sel = 5'd0; bus2.rs = 5'd1; bus2.rt = 5'd2; bus2.rd = 5'(i);
      bus2.in_valid = 1'b1;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      check("fill_wen",  32'(bus2.imem_wen), 32'd1);
      check("fill_addr", 32'(bus2.imem_addr), 32'(i));
      check("fill_data", bus2.imem_wdata, 32'h0022_0020 | (32'(i) << 11));
      @(negedge clk);
    end
    check("fill_ovf",   32'(overflow2), 32'd1);
    check("fill_done",  32'(load_done2), 32'd1);
    check("fill_words", 32'(words_written2), 32'd4);
    check("fill_ready", 32'(bus2.in_ready), 32'd0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("refill_ovf",   32'(overflow2), 32'd0);
    check("refill_done",  32'(load_done2), 32'd0);
    check("refill_words", 32'(words_written2), 32'd0);
    bus2.rd = 5'd5; bus2.in_valid = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    check("refill_wen",  32'(bus2.imem_wen), 32'd1);
    check("refill_addr", 32'(bus2.imem_addr), 32'd0);
    check("refill_data", bus2.imem_wdata, 32'h0022_2820);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
